lfsr_seq_gen: RTL and testbench
===============================

# lfsr_seq_gen

Parametrised LFSR sequence generator with seed load, run/stop control, target match detection and step counting. Supports Fibonacci or Galois form and any width up to 64 bits via a polynomial parameter. Also measures the sequence period: load a seed, set the target equal to the seed, and `steps` returns the period. Sits beside the replay-buffer address/pattern logic as the shared pseudo-random source and self-check engine.

## Interface
- `NBITS`, 16: register width, 2..64.
- `POLY`, 16'h6801: feedback polynomial excluding the x^NBITS term.
  - Bit i is the coefficient of x^i.
  - Bit 0 must be 1.
  - Default is x^16+x^14+x^13+x^11+1.
- `GALOIS`, 0: 0 = Fibonacci form, 1 = Galois form.
- `CNTW`, 32: width of the step counter.
- `SEED_RST`, 1: value `q` takes on reset. Must be nonzero.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `load`, in, 1: load `seed` into the register.
- `seed`, in, NBITS: load value.
- `target`, in, NBITS: match value. Sampled every RUN cycle.
- `start`, in, 1: begin stepping.
- `stop`, in, 1: abort stepping.
- `q`, out, NBITS: current register value.
- `busy`, out, 1: high in RUN.
- `match`, out, 1: one-cycle pulse when `q` becomes equal to `target`.
- `done`, out, 1: level, high in DONE.
- `timeout`, out, 1: level. The counter saturated without a match.
- `steps`, out, CNTW: number of advances since the last start.

## Operation
Next-state function (pure combinational):
- Fibonacci: fb = XOR over all i with POLY[i]=1 of q[NBITS-1-i]; next = {q[NBITS-2:0], fb}.
- Galois: next = {q[NBITS-2:0], 0} XOR (q[NBITS-1] ? POLY : 0).
- The all-zero value is never produced from a nonzero state. For a primitive POLY the period is 2^NBITS-1.

States: IDLE, RUN, DONE. The reset state is IDLE.
- `load` (any state, highest priority):
  - q <= seed, except seed==0 loads 1 (lock-up guard).
  - steps <= 0; match, done and timeout cleared; state -> IDLE.
- `start` in IDLE or DONE, no `load`:
  - steps <= 0; done, timeout and match cleared; state -> RUN.
  - `q` unchanged that cycle.
- `start` in RUN: ignored.
- RUN, no `load`/`stop`, each cycle:
  - q <= next; steps <= steps+1.
  - If next == target: state -> DONE, match <= 1 for one cycle, done <= 1.
  - Else if steps+1 == 2^CNTW-1: state -> DONE, timeout <= 1, match stays 0.
  - A match on the saturating step reports match, not timeout.
- `stop` in RUN (no `load`): state -> IDLE. `q` and `steps` hold, no advance.
- `stop` in other states: ignored.
- DONE: `q` and `steps` hold until `start` or `load`.
- IDLE: `q` and `steps` hold.
- `target` changes mid-RUN take effect on the next comparison.

## Timing
- Reset values: q = SEED_RST, steps = 0, busy = 0, match = 0, done = 0, timeout = 0.
- All outputs are registered. There is no combinational input-to-output path.
- `load` at edge k gives `q` = seed after edge k.
- `start` at edge k: busy = 1 after k. First advance at edge k+1, where steps = 1.
- Match on the advance at edge m: after m, q == target, match = 1, done = 1, busy = 0. After m+1, match = 0.
- `load` and `start` in the same cycle: `load` wins, `start` is dropped.
- `stop` and `start` in the same cycle while in RUN: `stop` wins.
- Reset mid-RUN: immediate return to reset values, regardless of clock.

## Structure
- Package `lfsr_pkg` holds:
  - state enum {IDLE, RUN, DONE};
  - primitive polynomial constants: LFSR_POLY4 = 4'h3, LFSR_POLY8 = 8'h1D, LFSR_POLY16 = 16'h6801;
  - the `lfsr_next(q, poly, galois)` function.
- Sub-module `lfsr_step`: combinational next-state (NBITS, POLY, GALOIS). It is reused by the checker side of the buffer.
- Top level: FSM, counter and compare.

## Test plan
1. NBITS=4, POLY=4'h3, Fibonacci, seed 4'h1, target 4'h9, start.
   - Required: `q` = 2, 4, 9; match on the third advance; steps = 3; done = 1.
2. Same, GALOIS=1, seed 4'h1, target 4'hB.
   - Required: `q` = 2, 4, 8, 3, 6, C, B; steps = 7; match pulse exactly one cycle.
3. Period check: NBITS=4, seed = target = 4'h5.
   - Required: steps = 15; q = 5; no timeout.
   - Repeat for NBITS=16 defaults: steps = 65535.
4. Timeout: NBITS=4, CNTW=4, target 4'h0, seed 4'h1.
   - Required: after 15 advances done = 1, timeout = 1, match never asserted.
5. Control edge cases:
   - seed 0 loads q = 1.
   - `stop` after 2 advances: busy = 0, q holds, steps = 2.
   - `load` + `start` in the same cycle: state IDLE.
   - `start` while busy: ignored.
6. Async reset asserted mid-RUN between clock edges: all outputs return to reset values immediately and stay there until the first post-reset `load`/`start`.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types, primitive polynomials and the LFSR next-state function
// for the pseudo-random sequence generator and its checker-side users.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lfsr_state_e;

    localparam logic [3:0]  LFSR_POLY4  = 4'h3;
    localparam logic [7:0]  LFSR_POLY8  = 8'h1D;
    localparam logic [15:0] LFSR_POLY16 = 16'h6801;

    // Operands are zero-extended to 64 bits so one function serves every width;
    // nbits selects the live portion and the result is masked back to it.
    function automatic logic [63:0] lfsr_next(
        input logic [63:0] q,
        input logic [63:0] poly,
        input logic        galois,
        input int          nbits
    );
        logic [63:0] nxt;
        logic [63:0] mask;
        logic        fb;
        nxt  = '0;
        fb   = 1'b0;
        mask = (64'd1 << nbits) - 64'd1;
        if (galois) begin
            nxt = q << 1;
            if (q[6'(nbits - 1)]) begin
                nxt = nxt ^ poly;
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (i < nbits && poly[6'(i)]) begin
                    fb = fb ^ q[6'(nbits - 1 - i)];
                end
            end
            nxt = (q << 1) | 64'(fb);
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR advance: one Fibonacci or Galois step of q_i.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               NBITS  = 16,
    parameter logic [NBITS-1:0] POLY   = LFSR_POLY16,
    parameter int               GALOIS = 0
) (
    input  logic [NBITS-1:0] q_i,
    output logic [NBITS-1:0] next_o
);

    assign next_o = NBITS'(lfsr_next(64'(q_i), 64'(POLY), GALOIS != 0, NBITS));

endmodule

// File: rtl/lfsr_seq_gen.sv
// LFSR sequence generator: seed load, run/stop control, target match,
// saturating step counter (also used to measure the sequence period).
module lfsr_seq_gen
    import lfsr_pkg::*;
#(
    parameter int               NBITS    = 16,
    parameter logic [NBITS-1:0] POLY     = 16'h6801,
    parameter int               GALOIS   = 0,
    parameter int               CNTW     = 32,
    parameter logic [NBITS-1:0] SEED_RST = NBITS'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [NBITS-1:0] seed,
    input  logic [NBITS-1:0] target,
    input  logic             start,
    input  logic             stop,
    output logic [NBITS-1:0] q,
    output logic             busy,
    output logic             match,
    output logic             done,
    output logic             timeout,
    output logic [CNTW-1:0]  steps
);

    lfsr_state_e      state_q, state_d;
    logic [NBITS-1:0] lfsr_q, lfsr_d;
    logic [CNTW-1:0]  steps_q, steps_d;
    logic             match_q, match_d;
    logic             timeout_q, timeout_d;

    logic [NBITS-1:0] lfsr_next_w;
    logic [CNTW-1:0]  steps_inc;
    logic             steps_sat;

    lfsr_step #(
        .NBITS  (NBITS),
        .POLY   (POLY),
        .GALOIS (GALOIS)
    ) u_step (
        .q_i    (lfsr_q),
        .next_o (lfsr_next_w)
    );

    assign steps_inc = steps_q + CNTW'(1);
    assign steps_sat = &steps_inc;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        steps_d   = steps_q;
        match_d   = 1'b0;
        timeout_d = timeout_q;

        if (load) begin
            // A zero seed would lock the register at zero forever.
            lfsr_d    = (seed == '0) ? NBITS'(1) : seed;
            steps_d   = '0;
            timeout_d = 1'b0;
            state_d   = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        steps_d   = '0;
                        timeout_d = 1'b0;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else begin
                        lfsr_d  = lfsr_next_w;
                        steps_d = steps_inc;
                        if (lfsr_next_w == target) begin
                            match_d = 1'b1;
                            state_d = DONE;
                        end else if (steps_sat) begin
                            timeout_d = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_RST;
            steps_q   <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            steps_q   <= steps_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
        end
    end

    assign q       = lfsr_q;
    assign steps   = steps_q;
    assign match   = match_q;
    assign timeout = timeout_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Self-checking bench: four generator configurations driven by directed and
// randomized runs, checked against a polynomial-arithmetic reference model.
module tb_lfsr_seq_gen;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instances: 0 = 4-bit Fibonacci, 1 = 4-bit Galois, 2 = 4-bit Fibonacci CNTW=4, 3 = 16-bit defaults.
    logic [3:0]  load_v, start_v, stop_v;
    logic [3:0]  seed4 [3];
    logic [3:0]  tgt4  [3];
    logic [15:0] seed16, tgt16;
    logic [3:0]  q4 [3];
    logic [15:0] q16;
    logic [31:0] st0, st1, st3;
    logic [3:0]  st2;
    logic [3:0]  busy_v, match_v, done_v, tmo_v;

    int          nb_c   [4] = '{4, 4, 4, 16};
    logic [15:0] poly_c [4] = '{16'h3, 16'h3, 16'h3, 16'h6801};
    bit          gal_c  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int          cntw_c [4] = '{32, 32, 4, 32};
    logic [15:0] mq     [4];

    int n_total = 0;
    int n_bad   = 0;

    lfsr_seq_gen #(.NBITS(4), .POLY(LFSR_POLY4), .GALOIS(0), .CNTW(32), .SEED_RST(4'h1)) u_fib4 (
        .clk(clk), .rst(rst), .load(load_v[0]), .seed(seed4[0]), .target(tgt4[0]),
        .start(start_v[0]), .stop(stop_v[0]), .q(q4[0]), .busy(busy_v[0]), .match(match_v[0]),
        .done(done_v[0]), .timeout(tmo_v[0]), .steps(st0));

    lfsr_seq_gen #(.NBITS(4), .POLY(LFSR_POLY4), .GALOIS(1), .CNTW(32), .SEED_RST(4'h1)) u_gal4 (
        .clk(clk), .rst(rst), .load(load_v[1]), .seed(seed4[1]), .target(tgt4[1]),
        .start(start_v[1]), .stop(stop_v[1]), .q(q4[1]), .busy(busy_v[1]), .match(match_v[1]),
        .done(done_v[1]), .timeout(tmo_v[1]), .steps(st1));

    lfsr_seq_gen #(.NBITS(4), .POLY(LFSR_POLY4), .GALOIS(0), .CNTW(4), .SEED_RST(4'h1)) u_sat4 (
        .clk(clk), .rst(rst), .load(load_v[2]), .seed(seed4[2]), .target(tgt4[2]),
        .start(start_v[2]), .stop(stop_v[2]), .q(q4[2]), .busy(busy_v[2]), .match(match_v[2]),
        .done(done_v[2]), .timeout(tmo_v[2]), .steps(st2));

    lfsr_seq_gen u_def16 (
        .clk(clk), .rst(rst), .load(load_v[3]), .seed(seed16), .target(tgt16),
        .start(start_v[3]), .stop(stop_v[3]), .q(q16), .busy(busy_v[3]), .match(match_v[3]),
        .done(done_v[3]), .timeout(tmo_v[3]), .steps(st3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Galois: multiply by x modulo P(x). Fibonacci: shift in the parity of the tapped bits.
    function automatic logic [15:0] m_next(input int d, input logic [15:0] v);
        int          n;
        logic [16:0] t;
        logic [16:0] full_poly;
        logic [15:0] taps;
        logic [15:0] mask;
        logic        fb;
        n    = nb_c[d];
        mask = 16'((17'd1 << n) - 17'd1);
        if (gal_c[d]) begin
            full_poly = (17'd1 << n) | {1'b0, poly_c[d]};
            t = {v, 1'b0};
            if (((t >> n) & 17'd1) != 17'd0) t = t ^ full_poly;
            return t[15:0] & mask;
        end
        taps = '0;
        for (int i = 0; i < n; i++) begin
            if (((poly_c[d] >> i) & 16'd1) != 16'd0) taps = taps | (16'd1 << (n - 1 - i));
        end
        fb = ($countones(v & taps) % 2) == 1;
        return ((v << 1) | {15'd0, fb}) & mask;
    endfunction

    function automatic logic [15:0] g_q(input int d);
        return (d == 3) ? q16 : {12'd0, q4[d]};
    endfunction

    function automatic logic [31:0] g_steps(input int d);
        case (d)
            0:       return st0;
            1:       return st1;
            2:       return {28'd0, st2};
            default: return st3;
        endcase
    endfunction

    task automatic set_seed(input int d, input logic [15:0] v);
        if (d == 3) seed16 = v;
        else        seed4[d] = v[3:0];
    endtask

    task automatic set_tgt(input int d, input logic [15:0] v);
        if (d == 3) tgt16 = v;
        else        tgt4[d] = v[3:0];
    endtask

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 4; d++) begin
            check({tag, "_q"}, g_q(d), 16'd1);
            check({tag, "_steps"}, g_steps(d), 0);
            check({tag, "_flags"}, {busy_v[d], match_v[d], done_v[d], tmo_v[d]}, 4'b0000);
        end
    endtask

    task automatic do_load(input int d, input logic [15:0] sv, input bit with_start);
        set_seed(d, sv);
        load_v[d]  = 1'b1;
        start_v[d] = with_start;
        @(posedge clk); #1;
        load_v[d]  = 1'b0;
        start_v[d] = 1'b0;
        mq[d] = (sv == 16'd0) ? 16'd1 : sv;
        check("load_q", g_q(d), mq[d]);
        check("load_steps", g_steps(d), 0);
        check("load_busy", busy_v[d], 0);
        check("load_done_tmo", {done_v[d], tmo_v[d]}, 2'b00);
    endtask

    // Starts a run and follows it cycle by cycle; stop_at > 0 aborts after that many advances.
    task automatic run(input int d, input logic [15:0] tv, input int stop_at, input bit poke_start);
        int          n;
        logic [63:0] sat;
        set_tgt(d, tv);
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        check("start_busy", busy_v[d], 1);
        check("start_steps", g_steps(d), 0);
        check("start_q", g_q(d), mq[d]);
        check("start_clr", {match_v[d], done_v[d], tmo_v[d]}, 3'b000);
        sat = (64'd1 << cntw_c[d]) - 64'd1;
        n = 0;
        for (int guard = 0; guard < 70000; guard++) begin
            if (stop_at > 0 && n == stop_at) begin
                stop_v[d]  = 1'b1;
                start_v[d] = 1'b1;
                @(posedge clk); #1;
                stop_v[d]  = 1'b0;
                start_v[d] = 1'b0;
                check("stop_busy", busy_v[d], 0);
                check("stop_q", g_q(d), mq[d]);
                check("stop_steps", g_steps(d), n);
                check("stop_flags", {match_v[d], done_v[d], tmo_v[d]}, 3'b000);
                return;
            end
            start_v[d] = poke_start && ($urandom_range(3) == 0);
            @(posedge clk); #1;
            start_v[d] = 1'b0;
            n++;
            mq[d] = m_next(d, mq[d]);
            check("run_q", g_q(d), mq[d]);
            check("run_steps", g_steps(d), n);
            if (mq[d] == tv) begin
                check("hit_flags", {busy_v[d], match_v[d], done_v[d], tmo_v[d]}, 4'b0110);
                @(posedge clk); #1;
                check("hit_after", {busy_v[d], match_v[d], done_v[d], tmo_v[d]}, 4'b0010);
                check("hit_hold_q", g_q(d), mq[d]);
                check("hit_hold_steps", g_steps(d), n);
                return;
            end else if (64'(n) == sat) begin
                check("sat_flags", {busy_v[d], match_v[d], done_v[d], tmo_v[d]}, 4'b0011);
                return;
            end else begin
                check("run_flags", {busy_v[d], match_v[d], done_v[d]}, 3'b100);
            end
        end
        n_total++;
        n_bad++;
        $display("FAIL run_bound: no match or timeout after %0d advances, expected termination", n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        logic [15:0] sv, tv;
        rst = 1'b1;
        load_v = '0; start_v = '0; stop_v = '0;
        seed16 = '0; tgt16 = '0;
        for (int i = 0; i < 3; i++) begin seed4[i] = '0; tgt4[i] = '0; end
        #2;
        check_reset_values("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_values("rst_idle");
        for (int i = 0; i < 4; i++) mq[i] = 16'd1;

        // Fibonacci 4-bit: 1 -> 2 -> 4 -> 9
        do_load(0, 16'h1, 1'b0);
        run(0, 16'h9, 0, 1'b0);
        check("t1_steps", st0, 3);
        check("t1_q", q4[0], 4'h9);

        // Galois 4-bit: 1 -> 2 -> 4 -> 8 -> 3 -> 6 -> C -> B
        do_load(1, 16'h1, 1'b0);
        run(1, 16'hB, 0, 1'b1);
        check("t2_steps", st1, 7);
        check("t2_q", q4[1], 4'hB);

        // Period measurement
        do_load(0, 16'h5, 1'b0);
        run(0, 16'h5, 0, 1'b0);
        check("t3_period4", st0, 15);
        check("t3_tmo4", tmo_v[0], 0);
        do_load(3, 16'h5, 1'b0);
        run(3, 16'h5, 0, 1'b0);
        check("t3_period16", st3, 65535);
        check("t3_q16", q16, 16'h5);

        // Counter saturation without a match
        do_load(2, 16'h1, 1'b0);
        run(2, 16'h0, 0, 1'b0);
        check("t4_steps", st2, 4'hF);
        check("t4_tmo", tmo_v[2], 1);

        // Control edge cases
        do_load(0, 16'h0, 1'b0);
        check("t5_zero_seed", q4[0], 4'h1);
        run(0, 16'h9, 2, 1'b0);
        check("t5_stop_q", q4[0], 4'h4);
        do_load(0, 16'h7, 1'b1);
        @(posedge clk); #1;
        check("t5_ld_st_busy", busy_v[0], 0);
        check("t5_ld_st_q", q4[0], 4'h7);

        // Randomized runs: random configs, seeds, targets, stops and restarts from DONE/IDLE
        for (int it = 0; it < 30; it++) begin
            d  = $urandom_range(2);
            sv = 16'($urandom_range(15));
            tv = 16'($urandom_range(15));
            if (d != 2 && tv == 16'd0) tv = 16'd1;
            if ($urandom_range(1) == 1) do_load(d, sv, 1'b0);
            run(d, tv, ($urandom_range(2) == 0) ? $urandom_range(1, 4) : 0, 1'b1);
        end

        // Asynchronous reset between clock edges in the middle of a run
        do_load(0, 16'h1, 1'b0);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst_hold");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
